// File: rtl/lbm_sequencer.sv
// lbm_sequencer: phase controller for the lattice-Boltzmann pipeline.
// Runs setup, then collide/stream pairs paced to the display frame.
module lbm_sequencer #(
  parameter int HPIXELS         = 320,
  parameter int VPIXELS         = 180,
  parameter int STEPS_PER_FRAME = 4,
  parameter int TIMEOUT_CYCLES  = 2*HPIXELS*VPIXELS+64,
  localparam int SW = $clog2(STEPS_PER_FRAME+1),
  localparam int CW = $clog2(TIMEOUT_CYCLES+1)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          start_in,
  input  logic          restart_in,
  input  logic          pause_in,
  input  logic [1:0]    setup_choice_in,
  input  logic          frame_sync_in,
  input  logic          setup_done_in,
  input  logic          collide_done_in,
  input  logic          stream_done_in,
  output logic          setup_start_out,
  output logic          collide_start_out,
  output logic          stream_start_out,
  output logic [1:0]    setup_choice_out,
  output logic [1:0]    owner_out,
  output logic [SW-1:0] step_out,
  output logic [15:0]   frames_out,
  output logic          busy_out,
  output logic          fault_out
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_COLLIDE = 3'd2;
  localparam logic [2:0] S_STREAM  = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  logic [2:0]    state;
  logic [2:0]    nxt;
  logic          go;
  logic          pending;
  logic [CW-1:0] cnt;
  logic          phase;
  logic          done;
  logic          tmo;
  logic          rst_req;
  logic          last_step;
  logic [1:0]    nxt_owner;

  assign phase   = (state == S_SETUP) || (state == S_COLLIDE) ||
                   (state == S_STREAM);
  assign tmo     = phase && (cnt == CW'(TIMEOUT_CYCLES-1));
  assign rst_req = pending || restart_in;
  assign last_step = (int'(step_out) + 1) >= STEPS_PER_FRAME;

  // done is only accepted from the second cycle of a phase onward
  always_comb begin
    done = 1'b0;
    if (cnt != '0) begin
      unique case (1'b1)
        (state == S_SETUP):   done = setup_done_in;
        (state == S_COLLIDE): done = collide_done_in;
        (state == S_STREAM):  done = stream_done_in;
        default:              done = 1'b0;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    go  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_in || restart_in) begin
          nxt = S_SETUP;
          go  = 1'b1;
        end
      end
      S_SETUP, S_COLLIDE, S_STREAM: begin
        if (done) begin
          go = 1'b1;
          if (rst_req)
            nxt = S_SETUP;
          else if (state == S_SETUP)
            nxt = S_COLLIDE;
          else if (state == S_COLLIDE)
            nxt = S_STREAM;
          else if (last_step)
            nxt = S_WAIT;
          else
            nxt = S_COLLIDE;
        end else if (tmo) begin
          nxt = S_FAULT;
          go  = 1'b1;
        end
      end
      S_WAIT: begin
        if (restart_in) begin
          nxt = S_SETUP;
          go  = 1'b1;
        end else if (frame_sync_in && !pause_in) begin
          nxt = S_COLLIDE;
          go  = 1'b1;
        end
      end
      S_FAULT: begin
        if (restart_in) begin
          nxt = S_SETUP;
          go  = 1'b1;
        end
      end
      default: begin
        nxt = S_IDLE;
        go  = 1'b1;
      end
    endcase
  end

  always_comb begin
    nxt_owner = 2'd0;
    unique case (nxt)
      S_SETUP:   nxt_owner = 2'd1;
      S_COLLIDE: nxt_owner = 2'd2;
      S_STREAM:  nxt_owner = 2'd3;
      default:   nxt_owner = 2'd0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state             <= S_IDLE;
      pending           <= 1'b0;
      cnt               <= '0;
      setup_start_out   <= 1'b0;
      collide_start_out <= 1'b0;
      stream_start_out  <= 1'b0;
      setup_choice_out  <= 2'd0;
      owner_out         <= 2'd0;
      step_out          <= '0;
      frames_out        <= 16'd0;
      busy_out          <= 1'b0;
      fault_out         <= 1'b0;
    end else begin
      setup_start_out   <= 1'b0;
      collide_start_out <= 1'b0;
      stream_start_out  <= 1'b0;
      if (go) begin
        state             <= nxt;
        pending           <= 1'b0;
        cnt               <= '0;
        setup_start_out   <= (nxt == S_SETUP);
        collide_start_out <= (nxt == S_COLLIDE);
        stream_start_out  <= (nxt == S_STREAM);
        owner_out         <= nxt_owner;
        busy_out          <= (nxt_owner != 2'd0);
        fault_out         <= (nxt == S_FAULT);
        if (nxt == S_SETUP)
          setup_choice_out <= setup_choice_in;
        if (state == S_SETUP && nxt == S_COLLIDE)
          step_out <= '0;
        if (state == S_STREAM && nxt == S_COLLIDE)
          step_out <= step_out + SW'(1);
        if (state == S_STREAM && nxt == S_WAIT) begin
          step_out   <= '0;
          frames_out <= frames_out + 16'd1;
        end
      end else begin
        if (phase) begin
          cnt <= cnt + CW'(1);
          if (restart_in)
            pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lbm_sequencer.sv
// tb_lbm_sequencer: directed checks of phase order, pacing,
// restart, timeout and ignored done pulses.
module tb_lbm_sequencer;

  localparam int SPF = 4;
  localparam int TMO = 50;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       start_in = 1'b0;
  logic       restart_in = 1'b0;
  logic       pause_in = 1'b0;
  logic [1:0] setup_choice_in = 2'd0;
  logic       frame_sync_in = 1'b0;
  logic       setup_done_in = 1'b0;
  logic       collide_done_in = 1'b0;
  logic       stream_done_in = 1'b0;
  logic       setup_start_out;
  logic       collide_start_out;
  logic       stream_start_out;
  logic [1:0] setup_choice_out;
  logic [1:0] owner_out;
  logic [2:0] step_out;
  logic [15:0] frames_out;
  logic       busy_out;
  logic       fault_out;

  int n_checks = 0;
  int n_errors = 0;

  lbm_sequencer #(
    .HPIXELS(16),
    .VPIXELS(8),
    .STEPS_PER_FRAME(SPF),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .start_in(start_in),
    .restart_in(restart_in),
    .pause_in(pause_in),
    .setup_choice_in(setup_choice_in),
    .frame_sync_in(frame_sync_in),
    .setup_done_in(setup_done_in),
    .collide_done_in(collide_done_in),
    .stream_done_in(stream_done_in),
    .setup_start_out(setup_start_out),
    .collide_start_out(collide_start_out),
    .stream_start_out(stream_start_out),
    .setup_choice_out(setup_choice_out),
    .owner_out(owner_out),
    .step_out(step_out),
    .frames_out(frames_out),
    .busy_out(busy_out),
    .fault_out(fault_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // 0 setup, 1 collide, 2 stream
  task automatic run_phase(input int cycles, input int which);
    repeat (cycles) tick();
    setup_done_in   = (which == 0);
    collide_done_in = (which == 1);
    stream_done_in  = (which == 2);
    tick();
    setup_done_in   = 1'b0;
    collide_done_in = 1'b0;
    stream_done_in  = 1'b0;
  endtask

  task automatic pulse_restart();
    restart_in = 1'b1;
    tick();
    restart_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_owner", owner_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_fault", fault_out, 0);
    check("rst_step", step_out, 0);
    check("rst_frames", frames_out, 0);
    check("rst_starts",
          {setup_start_out, collide_start_out, stream_start_out}, 0);
    check("rst_choice", setup_choice_out, 0);
    rst_n_in = 1'b1;
    tick();

    // start -> SETUP with choice 2
    setup_choice_in = 2'd2;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check("setup_start", setup_start_out, 1);
    check("setup_owner", owner_out, 1);
    check("setup_busy", busy_out, 1);
    check("setup_choice", setup_choice_out, 2);

    // done on the start cycle is ignored
    setup_done_in = 1'b1;
    setup_choice_in = 2'd3;
    tick();
    setup_done_in = 1'b0;
    check("start_done_ign_owner", owner_out, 1);
    check("start_done_ign_cs", collide_start_out, 0);
    check("setup_start_1cyc", setup_start_out, 0);
    check("choice_held", setup_choice_out, 2);

    run_phase(9, 0);
    check("collide_start", collide_start_out, 1);
    check("collide_owner", owner_out, 2);
    check("step_clear", step_out, 0);

    for (int i = 0; i < SPF; i++) begin
      if (i == 0) begin
        repeat (3) tick();
        stream_done_in = 1'b1;
        tick();
        stream_done_in = 1'b0;
        check("wrong_done_owner", owner_out, 2);
        check("wrong_done_ss", stream_start_out, 0);
        check("wrong_done_step", step_out, 0);
        run_phase(4, 1);
      end else begin
        run_phase(8, 1);
      end
      check("stream_start", stream_start_out, 1);
      check("stream_owner", owner_out, 3);
      run_phase(8, 2);
      if (i < SPF - 1) begin
        check("pair_cs", collide_start_out, 1);
        check("pair_step", step_out, i + 1);
      end else begin
        check("wait_owner", owner_out, 0);
        check("wait_busy", busy_out, 0);
        check("wait_frames", frames_out, 1);
        check("wait_step", step_out, 0);
        check("wait_cs", collide_start_out, 0);
      end
    end

    // paused: frame syncs ignored
    pause_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      repeat (2) tick();
      frame_sync_in = 1'b1;
      tick();
      frame_sync_in = 1'b0;
      check("pause_cs", collide_start_out, 0);
      check("pause_owner", owner_out, 0);
      check("pause_frames", frames_out, 1);
    end
    pause_in = 1'b0;
    tick();
    frame_sync_in = 1'b1;
    tick();
    frame_sync_in = 1'b0;
    check("resume_cs", collide_start_out, 1);
    check("resume_owner", owner_out, 2);
    check("resume_step", step_out, 0);

    // restart mid-COLLIDE waits for collide done
    setup_choice_in = 2'd1;
    repeat (3) tick();
    pulse_restart();
    repeat (3) tick();
    check("pend_owner", owner_out, 2);
    check("pend_ss", setup_start_out, 0);
    run_phase(0, 1);
    check("restart_ss", setup_start_out, 1);
    check("restart_choice", setup_choice_out, 1);
    check("restart_no_stream", stream_start_out, 0);
    check("restart_owner", owner_out, 1);
    run_phase(4, 0);
    check("re_cs", collide_start_out, 1);

    // timeout in COLLIDE: FAULT at entry+TMO
    repeat (TMO - 1) tick();
    check("pre_tmo_owner", owner_out, 2);
    check("pre_tmo_fault", fault_out, 0);
    tick();
    check("tmo_fault", fault_out, 1);
    check("tmo_owner", owner_out, 0);
    check("tmo_busy", busy_out, 0);
    repeat (5) tick();
    collide_done_in = 1'b1;
    frame_sync_in = 1'b1;
    tick();
    collide_done_in = 1'b0;
    frame_sync_in = 1'b0;
    check("fault_sticky", fault_out, 1);
    check("fault_no_cs", collide_start_out, 0);
    pulse_restart();
    check("fault_exit_ss", setup_start_out, 1);
    check("fault_exit_fault", fault_out, 0);
    check("fault_exit_owner", owner_out, 1);

    // restart beats frame_sync in WAIT_FRAME
    run_phase(2, 0);
    for (int i = 0; i < SPF; i++) begin
      run_phase(2, 1);
      run_phase(2, 2);
    end
    check("wait2_frames", frames_out, 2);
    frame_sync_in = 1'b1;
    restart_in = 1'b1;
    tick();
    frame_sync_in = 1'b0;
    restart_in = 1'b0;
    check("wait_restart_ss", setup_start_out, 1);
    check("wait_restart_cs", collide_start_out, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lbm_sequencer.md
# lbm_sequencer

Top-level phase controller for the lattice-Boltzmann fluid pipeline. It runs the one-time lattice initialisation (setup engine), then alternates collide and stream passes over the nine distribution BRAMs. It paces the passes to the display frame and grants BRAM ownership to exactly one client at a time. It sits between the top-level controls, the three lattice engines and the BRAM port muxes.

## Interface
- HPIXELS, 320: lattice width in cells; passed through for engine sizing only.
- VPIXELS, 180: lattice height in cells.
- STEPS_PER_FRAME, 4: collide+stream pairs per display frame; minimum 1.
- TIMEOUT_CYCLES, 2*HPIXELS*VPIXELS+64: maximum cycles any phase may take before a fault is raised.

- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous, active-low reset
- start_in  input  1  one-cycle pulse; starts the first setup from IDLE
- restart_in  input  1  one-cycle pulse; requests re-initialisation
- pause_in  input  1  level; holds the simulation at the frame boundary
- setup_choice_in  input  2  barrier selection; latched when SETUP is entered
- frame_sync_in  input  1  one-cycle pulse at display vsync
- setup_done_in / collide_done_in / stream_done_in  input  1 each  one-cycle completion pulses from the engines
- setup_start_out / collide_start_out / stream_start_out  output  1 each  one-cycle start pulses
- setup_choice_out  output  2  latched choice, held stable for the whole SETUP phase
- owner_out  output  2  BRAM owner: 0 display, 1 setup, 2 collide, 3 stream
- step_out  output  $clog2(STEPS_PER_FRAME+1)  completed pairs in the current batch
- frames_out  output  16  completed batches; wraps 0xFFFF→0
- busy_out  output  1  high in SETUP, COLLIDE and STREAM
- fault_out  output  1  sticky timeout flag

## Operation
- States: IDLE, SETUP, COLLIDE, STREAM, WAIT_FRAME, FAULT.
- IDLE:
  - start_in → SETUP.
  - restart_in in IDLE is equivalent to start_in.
- SETUP: on setup_done_in → COLLIDE. step_out is cleared at this transition.
- COLLIDE: on collide_done_in → STREAM.
- STREAM: on stream_done_in, step_out increments.
  - If the new value is below STEPS_PER_FRAME → COLLIDE.
  - Otherwise → WAIT_FRAME. frames_out increments and step_out clears.
- WAIT_FRAME:
  - Owner is the display.
  - On frame_sync_in with pause_in low → COLLIDE.
  - With pause_in high, frame_sync_in is ignored and the block stays in WAIT_FRAME.
- restart_in arriving in SETUP, COLLIDE or STREAM is latched as pending. It is never aborted mid-pass.
  - At the next done pulse of the current phase, the block goes to SETUP instead of the normal successor. The pending flag clears.
  - In WAIT_FRAME, restart_in goes directly to SETUP.
- Timeout:
  - A phase counter clears on every phase entry and counts cycles while in SETUP, COLLIDE or STREAM.
  - When it reaches TIMEOUT_CYCLES without a done pulse, the block goes to FAULT and fault_out sets.
  - FAULT: owner is the display. Only restart_in (→ SETUP, fault_out clears) or reset leaves FAULT.
- owner_out per state:
  - IDLE, WAIT_FRAME, FAULT: 0.
  - SETUP: 1. COLLIDE: 2. STREAM: 3.
- done pulses for a phase other than the current one are ignored.

## Timing
- All outputs are registered.
- Reset values:
  - State is IDLE; the restart-pending flag is clear.
  - All start pulses, busy_out and fault_out are 0.
  - owner_out, step_out, frames_out and setup_choice_out are 0.
- Transition decided at cycle N: at N+1 the new state, owner_out and busy_out are visible, and the matching *_start_out is high for exactly cycle N+1.
- setup_choice_out updates at N+1 together with setup_start_out.
- A done pulse coincident with the start cycle (N+1) is ignored. Done is accepted from N+2 onward.
- Phase transition latency: done at cycle N → next start pulse at N+1 (one-cycle turnaround). Owner changes in the same cycle as the start pulse, so no idle gap is needed.
- Simultaneous events:
  - Done and timeout in the same cycle: done wins.
  - restart_in and done in the same cycle: goes to SETUP.
  - restart_in and frame_sync_in in WAIT_FRAME: restart wins.
- Reset asserted mid-phase clears everything asynchronously. Engines must themselves be reset on the same rst_n_in.

## Test plan
- Reset, start_in at cycle 5, setup_done_in 10 cycles after setup_start_out → setup_start_out high at cycle 6, owner 1 during SETUP, collide_start_out one cycle after done, owner 2.
- STEPS_PER_FRAME=4, engines answering done after 8 cycles → 4 collide/stream pairs, then WAIT_FRAME with owner 0, frames_out=1; frame_sync_in → collide_start_out next cycle, step_out=0.
- pause_in high in WAIT_FRAME, 3 frame_sync_in pulses → no start pulses, frames_out unchanged; drop pause_in, next frame_sync_in → COLLIDE.
- restart_in mid-COLLIDE with setup_choice_in=1 → COLLIDE completes on collide_done_in, then setup_start_out with setup_choice_out=1, no stream_start_out.
- TIMEOUT_CYCLES=50, collide_done_in never sent → FAULT at cycle 50 after entry, fault_out=1, owner 0; restart_in → SETUP, fault_out=0.
- stream_done_in pulsed during COLLIDE, and done pulses on the start cycle → ignored; state and counters unchanged.
